adc_bcd_converter: RTL and testbench



---
 rtl/adc_display_pkg.sv | 16 +
 rtl/adc_bcd_converter_dabble_digit.sv | 14 +
 rtl/adc_bcd_converter.sv | 120 ++++++++++++
 tb/tb_adc_bcd_converter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/adc_display_pkg.sv
// Shared types and constants for the ADC display path (BCD converter and display multiplexer).
// Contents: converter FSM state encoding, BCD digit width and the BCD digit type.
// No logic lives here; both the converter and the multiplexer import it.
package adc_display_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/adc_bcd_converter_dabble_digit.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more, so that
// the following left shift carries into the next digit instead of leaving a value >= 10.
// Ports: din - working digit before the shift; dout - corrected digit. Purely combinational.
module dabble_digit
    import adc_display_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    // 5..9 map to 8..12, which never overflow four bits.
    assign dout = (din >= bcd_digit_t'(5)) ? din + bcd_digit_t'(3) : din;

endmodule

// File: rtl/adc_bcd_converter.sv
// Sequential double-dabble converter: binary ADC reading (mV) to packed BCD plus a
// leading-zero blanking mask, one bit per clock; start->done latency is N+1 clocks.
// Ports: clk, reset (sync, active-high), start/bin request in; busy, done pulse, bcd, blank out.
// start is only accepted in IDLE (including the done cycle); requests while busy are dropped.
module adc_bcd_converter
    import adc_display_pkg::*;
#(
    parameter int N      = 16,
    parameter int DIGITS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N-1:0]             bin,
    output logic                     busy,
    output logic                     done,
    output logic [BCD_W*DIGITS-1:0]  bcd,
    output logic [DIGITS-1:0]        blank
);

    localparam int BCD_BITS = BCD_W * DIGITS;
    localparam int CNT_W    = $clog2(N) + 1;

    // Every digit except the least significant one is blanked out of reset.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    // True when DIGITS decimal digits can hold the largest N-bit value.
    function automatic logic digits_fit(input int n, input int d);
        longint unsigned pow10;
        longint unsigned max_bin;
        pow10 = 1;
        for (int i = 0; i < d; i++) begin
            pow10 = pow10 * 10;
        end
        max_bin = (longint'(1) << n) - 1;
        return pow10 > max_bin;
    endfunction

    generate
        if (!digits_fit(N, DIGITS)) begin : g_bad_params
            $error("adc_bcd_converter: DIGITS too small for N-bit input");
        end
    endgenerate

    conv_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [N-1:0]           bin_shift;
    logic [BCD_BITS-1:0]    bcd_work;
    logic [BCD_BITS-1:0]    bcd_adj;
    logic [BCD_BITS+N-1:0]  shifted;
    logic [DIGITS-1:0]      blank_next;

    // Add-3 correction on every working digit ahead of each shift.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            dabble_digit u_dabble_digit (
                .din  (bcd_work[g*BCD_W +: BCD_W]),
                .dout (bcd_adj[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // The binary register's MSB shifts into bit 0 of the BCD register.
    assign shifted = {bcd_adj, bin_shift} << 1;

    // A digit is blanked only if it and everything above it is zero; digit 0
    // always shows so a zero reading still displays "0".
    always_comb begin
        logic all_zero;
        blank_next = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (bcd_work[i*BCD_W +: BCD_W] == '0);
            blank_next[i] = all_zero;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bin_shift <= '0;
            bcd_work  <= '0;
            bcd       <= '0;
            blank     <= BLANK_RST;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_shift <= bin;
                        bcd_work  <= '0;
                        cnt       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_work, bin_shift} <= shifted;
                    cnt                   <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= bcd_work;
                    blank <= blank_next;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_bcd_converter.sv
module tb_adc_bcd_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    int checks;
    int errors;

    adc_bcd_converter #(.N(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller is at a negedge. Pulses start for one edge, then waits (bounded) for done.
    // Returns at the negedge where done is seen; lat = clocks after the accepting edge,
    // -1 on timeout; bcyc = busy samples seen up to and including the done cycle.
    task automatic conv(input logic [15:0] v, output int lat, output int bcyc);
        start = 1'b1;
        bin   = v;
        lat   = -1;
        bcyc  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy === 1'b1) bcyc++;
            if (done === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (bcd !== 20'h00000) begin errors++; $display("FAIL reset_bcd got %h want 00000", bcd); end
        checks++; if (blank !== 5'b11110) begin errors++; $display("FAIL reset_blank got %b want 11110", blank); end
    endtask

    task automatic test_zero();
        int lat, bcyc;
        conv(16'd0, lat, bcyc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency got %0d want 17", lat); end
        checks++; if (bcd !== 20'h00000) begin errors++; $display("FAIL zero_bcd got %h want 00000", bcd); end
        checks++; if (blank !== 5'b11110) begin errors++; $display("FAIL zero_blank got %b want 11110", blank); end
        @(negedge clk);
    endtask

    task automatic test_3300();
        int lat, bcyc;
        conv(16'd3300, lat, bcyc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL v3300_latency got %0d want 17", lat); end
        checks++; if (bcyc !== 17) begin errors++; $display("FAIL v3300_busy_cycles got %0d want 17", bcyc); end
        checks++; if (bcd !== 20'h03300) begin errors++; $display("FAIL v3300_bcd got %h want 03300", bcd); end
        checks++; if (blank !== 5'b10000) begin errors++; $display("FAIL v3300_blank got %b want 10000", blank); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL v3300_done_pulse got %b want 0", done); end
        checks++; if (bcd !== 20'h03300) begin errors++; $display("FAIL v3300_bcd_hold got %h want 03300", bcd); end
    endtask

    task automatic test_values();
        int lat, bcyc;
        conv(16'd65535, lat, bcyc);
        checks++; if (bcd !== 20'h65535) begin errors++; $display("FAIL v65535_bcd got %h want 65535", bcd); end
        checks++; if (blank !== 5'b00000) begin errors++; $display("FAIL v65535_blank got %b want 00000", blank); end
        @(negedge clk);
        conv(16'd9, lat, bcyc);
        checks++; if (bcd !== 20'h00009) begin errors++; $display("FAIL v9_bcd got %h want 00009", bcd); end
        checks++; if (blank !== 5'b11110) begin errors++; $display("FAIL v9_blank got %b want 11110", blank); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int first_lat, ndone;
        first_lat = -1;
        ndone     = 0;
        start = 1'b1;
        bin   = 16'd1234;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 6) begin
                start = 1'b1;
                bin   = 16'd42;
            end
            if (done === 1'b1) begin
                ndone++;
                if (first_lat < 0) begin
                    first_lat = i - 1;
                    checks++; if (bcd !== 20'h01234) begin errors++; $display("FAIL busy_start_bcd got %h want 01234", bcd); end
                end
            end
        end
        checks++; if (first_lat !== 17) begin errors++; $display("FAIL busy_start_latency got %0d want 17", first_lat); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
        checks++; if (bcd !== 20'h01234) begin errors++; $display("FAIL busy_start_bcd_final got %h want 01234", bcd); end
    endtask

    task automatic test_back_to_back();
        int lat, bcyc;
        conv(16'd100, lat, bcyc);
        checks++; if (bcd !== 20'h00100) begin errors++; $display("FAIL b2b_first_bcd got %h want 00100", bcd); end
        // Still in the done cycle: the next request must be accepted here.
        conv(16'd250, lat, bcyc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_second_latency got %0d want 17", lat); end
        checks++; if (bcd !== 20'h00250) begin errors++; $display("FAIL b2b_second_bcd got %h want 00250", bcd); end
        checks++; if (blank !== 5'b11000) begin errors++; $display("FAIL b2b_second_blank got %b want 11000", blank); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bcyc, ndone;
        ndone = 0;
        start = 1'b1;
        bin   = 16'd4095;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
        checks++; if (bcd !== 20'h00000) begin errors++; $display("FAIL midreset_bcd got %h want 00000", bcd); end
        checks++; if (blank !== 5'b11110) begin errors++; $display("FAIL midreset_blank got %b want 11110", blank); end
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", ndone); end
        conv(16'd4095, lat, bcyc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL v4095_latency got %0d want 17", lat); end
        checks++; if (bcd !== 20'h04095) begin errors++; $display("FAIL v4095_bcd got %h want 04095", bcd); end
        checks++; if (blank !== 5'b10000) begin errors++; $display("FAIL v4095_blank got %b want 10000", blank); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bin    = '0;
        test_reset();
        test_zero();
        test_3300();
        test_values();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
